updown_mod_counter: RTL and testbench

- Synchronous, parametrised up/down modulo counter with enable, parallel load, prescaler and terminal-count pulse.
- Next-generation replacement for the fixed-width ripple counters.
- All state changes on one clock edge, so there is no ripple skew and outputs are safe to use as a bus.
- Used as a general event/period counter and as a clock-enable generator for downstream logic.

---
 rtl/updown_counter_pkg.sv | 21 ++
 rtl/cnt_prescaler.sv | 46 ++++
 rtl/updown_mod_counter.sv | 99 +++++++++
 tb/tb_updown_mod_counter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/updown_counter_pkg.sv
//==============================================================================
// Module      : updown_counter_pkg
// Description : Direction constants and load-clamp helper shared by the
//               up/down modulo counter and its prescaler.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package updown_counter_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Largest value the counter may hold for a given modulus.
  function automatic int unsigned clamp_value(input int unsigned modulus);
    return modulus - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cnt_prescaler.sv
//==============================================================================
// Module      : cnt_prescaler
// Description : Divides enabled clocks by PRESCALE and emits a step tick.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cnt_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int              c_PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_PW-1:0] c_LAST = c_PW'(PRESCALE - 1);

  logic [c_PW-1:0] r_cnt;
  logic            w_tick;

  generate
    if (PRESCALE < 1) begin : g_bad_prescale
      $fatal(1, "cnt_prescaler: PRESCALE must be >= 1");
    end
  endgenerate

  // With PRESCALE = 1, c_LAST is 0, so the phase counter never leaves 0.
  assign w_tick = en & ~clr & (r_cnt == c_LAST);
  assign tick   = w_tick;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clr || w_tick) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/updown_mod_counter.sv
//==============================================================================
// Module      : updown_mod_counter
// Description : Synchronous up/down modulo counter with enable, clamped load,
//               prescaler and one-cycle terminal-count pulse.
//               Define UPDOWN_MOD_COUNTER_SATURATE_EN to saturate instead of wrap.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module updown_mod_counter
  import updown_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  localparam logic [WIDTH-1:0] c_MAX = WIDTH'(clamp_value(MODULUS));

  logic [WIDTH-1:0] r_q;
  logic             r_tc;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_tc_nxt;
  logic             w_tick;

  generate
    if ((MODULUS < 2) || (longint'(MODULUS) > (longint'(1) << WIDTH))) begin : g_bad_modulus
      $fatal(1, "updown_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
  endgenerate

  cnt_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .en    (en),
    .clr   (load),
    .tick  (w_tick)
  );

  always_comb begin
    w_q_nxt  = r_q;
    w_tc_nxt = 1'b0;
    if (load) begin
      // MODULUS may be 2**WIDTH, so compare against the top value instead.
      w_q_nxt = (load_val > c_MAX) ? c_MAX : load_val;
    end else if (w_tick) begin
      if (up_dn == DIR_UP) begin
        if (r_q == c_MAX) begin
          w_tc_nxt = 1'b1;
`ifdef UPDOWN_MOD_COUNTER_SATURATE_EN
          w_q_nxt  = r_q;
`else
          w_q_nxt  = '0;
`endif
        end else begin
          w_q_nxt = r_q + 1'b1;
        end
      end else begin
        if (r_q == '0) begin
          w_tc_nxt = 1'b1;
`ifdef UPDOWN_MOD_COUNTER_SATURATE_EN
          w_q_nxt  = r_q;
`else
          w_q_nxt  = c_MAX;
`endif
        end else begin
          w_q_nxt = r_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_q  <= '0;
      r_tc <= 1'b0;
    end else begin
      r_q  <= w_q_nxt;
      r_tc <= w_tc_nxt;
    end
  end

  assign q  = r_q;
  assign tc = r_tc;

endmodule

`default_nettype wire

// File: tb/tb_updown_mod_counter.sv
//==============================================================================
// Module      : tb_updown_mod_counter
// Description : Randomized self-checking bench for two counter instances
//               (PRESCALE 1 and 3) against a behavioural model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_updown_mod_counter;

  localparam int c_W = 4;
  localparam int c_M = 10;
  localparam int c_N = 2;

  logic           clock;
  logic           reset;
  logic           en;
  logic           up_dn;
  logic           load;
  logic [c_W-1:0] load_val;
  logic [c_W-1:0] q_p1;
  logic [c_W-1:0] q_p3;
  logic           tc_p1;
  logic           tc_p3;

  int n_checks = 0;
  int n_fail   = 0;

  int mq  [c_N];
  int mps [c_N];
  int mtc [c_N];
  int pre [c_N] = '{1, 3};

  updown_mod_counter #(.WIDTH(c_W), .MODULUS(c_M), .PRESCALE(1)) u_dut_p1 (
    .clock(clock), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .q(q_p1), .tc(tc_p1)
  );

  updown_mod_counter #(.WIDTH(c_W), .MODULUS(c_M), .PRESCALE(3)) u_dut_p3 (
    .clock(clock), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .q(q_p3), .tc(tc_p3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < c_N; k++) begin
      mq[k] = 0; mps[k] = 0; mtc[k] = 0;
    end
  endtask

  // One rising edge of the ideal counter, expressed with plain integers.
  task automatic model_edge();
    int target;
    bit sat;
`ifdef UPDOWN_MOD_COUNTER_SATURATE_EN
    sat = 1'b1;
`else
    sat = 1'b0;
`endif
    for (int k = 0; k < c_N; k++) begin
      mtc[k] = 0;
      if (load) begin
        mq[k]  = (int'(load_val) > c_M - 1) ? c_M - 1 : int'(load_val);
        mps[k] = 0;
      end else if (en) begin
        mps[k] = mps[k] + 1;
        if (mps[k] == pre[k]) begin
          mps[k] = 0;
          target = mq[k] + (up_dn ? 1 : -1);
          if (target < 0 || target >= c_M) begin
            mtc[k] = 1;
            if (!sat) mq[k] = (target + c_M) % c_M;
          end else begin
            mq[k] = target;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    check("q_p1",  int'(q_p1),  mq[0]);
    check("tc_p1", int'(tc_p1), mtc[0]);
    check("q_p3",  int'(q_p3),  mq[1]);
    check("tc_p3", int'(tc_p3), mtc[1]);
  endtask

  task automatic cycle();
    @(posedge clock);
    if (!reset) model_clear();
    else        model_edge();
    #1;
    compare_all();
  endtask

  task automatic rand_inputs();
    en       = ($urandom_range(0, 3) != 0);
    up_dn    = $urandom_range(0, 1) == 1;
    load     = ($urandom_range(0, 15) == 0);
    load_val = c_W'($urandom_range(0, 15));
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
    model_clear();

    // reset held low across edges, with inputs active
    en = 1'b1; load = 1'b1; load_val = 4'd7;
    repeat (3) cycle();
    load = 1'b0;
    reset = 1'b1;

    // up count through the wrap
    en = 1'b1; up_dn = 1'b1;
    repeat (12) cycle();

    // load beats enable; out-of-range value clamps
    load = 1'b1; load_val = 4'd13;
    cycle();
    check("clamp_13", int'(q_p1), 9);
    load_val = 4'd5;
    cycle();
    check("load_5", int'(q_p3), 5);

    // down count with prescale through underflow
    load_val = 4'd1;
    cycle();
    load = 1'b0; up_dn = 1'b0;
    repeat (9) cycle();

    // enable pause mid-prescale with direction flips
    up_dn = 1'b1;
    repeat (2) cycle();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      up_dn = ~up_dn;
      cycle();
    end
    en = 1'b1; up_dn = 1'b0;
    repeat (4) cycle();

    // boundary loads then a single step each way
    load = 1'b1; load_val = 4'd9; cycle();
    load = 1'b0; up_dn = 1'b1; cycle();
    load = 1'b1; load_val = 4'd0; cycle();
    load = 1'b0; up_dn = 1'b0; cycle();

    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      cycle();
    end

    // asynchronous reset between edges
    load = 1'b1; load_val = 4'd9; en = 1'b0;
    cycle();
    load = 1'b0; en = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    check("async_q_p1", int'(q_p1), 0);
    check("async_q_p3", int'(q_p3), 0);
    check("async_tc_p1", int'(tc_p1), 0);
    repeat (2) cycle();
    reset = 1'b1;

    for (int i = 0; i < 40; i++) begin
      rand_inputs();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
